// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the pipeline MEM stage:
//               FSM state encoding, datapath/register widths, the width of
//               the bus-timeout counter and the default timeout value.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int CTR_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : 8-bit wait-cycle counter for an outstanding data-memory
//               request, with terminal-count compare against TIMEOUT.
// Ports       : clk    - clock
//               reset  - asynchronous active-low reset
//               i_clr  - synchronous clear (has priority over i_en)
//               i_en   - count enable
//               o_tc   - count has reached TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CTR_W-1:0] c_TC_VALUE = CTR_W'(TIMEOUT);

  logic [CTR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CTR_W'(1);
    end
  end

  assign o_tc = (r_count == c_TC_VALUE);

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. ALU ops pass straight through to the
//               MEM/WB register. Aligned loads/stores run a registered
//               request/ack handshake (IDLE -> REQ -> DONE) while stalling
//               the front of the pipe; misaligned accesses and bus timeouts
//               produce one-cycle error pulses and suppress the write-back.
// Ports       : clk, reset (async active-low)
//               alu_res/write_data/write_reg/MemRead/MemWrite/MemToReg/
//               RegWrite            - EX/MEM inputs
//               dmem_req/we/addr/wdata, dmem_ack/rdata - data-memory bus
//               alu_res_out/mem_read_out/write_reg_out/MemToReg_out/
//               RegWrite_out/bubble_out - to MEM/WB register
//               stall               - freezes PC and earlier pipe registers
//               misalign_err/bus_err - one-cycle error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              RegWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_read_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic              bubble_out,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err
);

  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_mem_op;
  logic w_misalign;
  logic w_start;
  logic w_tc;

  // Gating with reset keeps stall/bubble/misalign low while reset is held,
  // so the stage looks like a plain pass-through during reset.
  assign w_mem_op   = (MemRead | MemWrite) & reset;
  assign w_misalign = w_mem_op & (alu_res[1:0] != 2'b00);
  assign w_start    = w_mem_op & ~w_misalign;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state == ST_IDLE),
    .i_en  ((r_state == ST_REQ) & ~dmem_ack),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite;
            r_addr  <= alu_res;
            r_wdata <= write_data;
            r_err   <= 1'b0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is checked first so an ack coinciding with terminal count wins.
          if (dmem_ack) begin
            if (!r_we) begin
              r_rdata <= dmem_rdata;
            end
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_tc) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  assign alu_res_out   = alu_res;
  assign write_reg_out = write_reg;
  assign MemToReg_out  = MemToReg;

  always_comb begin
    mem_read_out = '0;
    RegWrite_out = RegWrite;
    bubble_out   = 1'b0;
    stall        = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall        = w_start;
        bubble_out   = w_start;
        misalign_err = w_misalign;
        RegWrite_out = RegWrite & ~w_misalign;
      end
      ST_REQ: begin
        stall      = 1'b1;
        bubble_out = 1'b1;
      end
      ST_DONE: begin
        mem_read_out = r_rdata;
        RegWrite_out = RegWrite & ~r_err;
        bus_err      = r_err;
      end
      default: begin
        mem_read_out = '0;
      end
    endcase
  end

endmodule : mem_stage
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 TIMEOUT, 255, max cycles in REQ awaiting dmem_ack before bus error (1..255).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 alu_res  in  32  EX/MEM ALU result; byte address for loads/stores.
REQ-005 write_data  in  32  EX/MEM store data.
REQ-006 write_reg  in  5  EX/MEM destination register.
REQ-007 MemRead, MemWrite, MemToReg, RegWrite  in  1 each  EX/MEM control signals.
REQ-008 dmem_req  out  1  data-memory request, registered, held until ack.
REQ-009 dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-010 dmem_addr, dmem_wdata  out  32 each  latched address/data; valid while dmem_req=1.
REQ-011 dmem_ack  in  1  one-cycle completion strobe; dmem_rdata valid in that cycle.
REQ-012 dmem_rdata  in  32  load data.
REQ-013 alu_res_out, mem_read_out  out  32 each  to MEM/WB register.
REQ-014 write_reg_out  out  5  to MEM/WB register.
REQ-015 MemToReg_out, RegWrite_out  out  1 each  to MEM/WB register.
REQ-016 bubble_out  out  1  drives the MEM/WB register bubble input.
REQ-017 stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-018 misalign_err, bus_err  out  1 each  one-cycle error pulses.

Function
REQ-019 FSM states IDLE, REQ, DONE; no other states reachable.
REQ-020 IDLE, MemRead=MemWrite=0: zero-latency combinational pass-through of alu_res, write_reg, MemToReg, RegWrite; mem_read_out=0; stall=0; bubble_out=0.
REQ-021 IDLE, mem op, alu_res[1:0]!=0: no request; pass-through with RegWrite_out=0; misalign_err=1 for that cycle; stall=0; state stays IDLE.
REQ-022 IDLE, mem op, aligned: stall=1, bubble_out=1; next edge latches addr/wdata/we, sets dmem_req=1, clears timeout counter, enters REQ.
REQ-023 REQ: stall=1, bubble_out=1; dmem_req held with stable addr/wdata/we; counter increments each cycle without ack.
REQ-024 REQ with dmem_ack=1: next edge captures dmem_rdata into rdata_q (loads only), drops dmem_req, enters DONE.
REQ-025 REQ with counter=TIMEOUT and no ack: next edge drops dmem_req, sets error flag, enters DONE; bus_err pulses in DONE.
REQ-026 ack arriving in the same cycle as timeout: ack wins, no bus_err.
REQ-027 DONE: stall=0, bubble_out=0; outputs from current EX/MEM inputs; mem_read_out=rdata_q; RegWrite_out=0 if bus error, else RegWrite; next edge returns to IDLE.
REQ-028 Minimum memory-op latency 3 cycles (IDLE, REQ, DONE) with zero-wait ack; stall low only in DONE.
REQ-029 dmem_ack outside REQ is ignored.
REQ-030 Stores: mem_read_out=rdata_q is don't-care; RegWrite as supplied (normally 0).

Reset
REQ-031 reset=0: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rdata_q=0, counter=0, error flag=0, asynchronously.
REQ-032 Reset during REQ aborts the access; dmem_req falls without waiting for clk; no error pulse.
REQ-033 During reset, combinational outputs follow REQ-020 with stall=0, bubble_out=0.

Structure
REQ-034 Shared package mem_stage_pkg holds state enum, TIMEOUT default, data/reg width constants.
REQ-035 One sub-module mem_timeout_ctr: 8-bit counter with clear, enable, terminal-count compare against TIMEOUT.

Verification
REQ-036 ALU op (MemRead=MemWrite=0, alu_res=0x1234, RegWrite=1) -> same-cycle pass-through, stall=0, bubble_out=0.
REQ-037 Load addr 0x100, ack in first REQ cycle, rdata=0xDEADBEEF -> stall high 2 cycles, DONE mem_read_out=0xDEADBEEF, RegWrite_out=1.
REQ-038 Store addr 0x204, wdata=0xA5A5A5A5, ack after 4 wait cycles -> dmem_addr/wdata/we stable throughout REQ, req drops after ack.
REQ-039 Load addr 0x102 -> no dmem_req, misalign_err one cycle, RegWrite_out=0.
REQ-040 TIMEOUT=8, no ack -> req held 9 cycles, bus_err pulse in DONE, RegWrite_out=0; ack on cycle 9 -> no bus_err.
REQ-041 reset low mid-REQ -> dmem_req=0 before next clk edge, state IDLE, stall=0.
